speck_enc_ctrl: RTL
===================

// Module: speck_enc_ctrl
// PURPOSE
//  Iterative Speck64/128 encryption controller. Holds state and key-schedule registers and drives
//  two speck_round instances once per clock: one on data, one on the key schedule.
//  Sits between the UART command/response logic and the round datapath.
//  One block encrypted per start pulse; the result is held until the next accepted start.
// PARAMETERS
//  W       32  word width in bits (rotations: alpha=8, beta=3)
//  M       4   key words (key = M*W bits)
//  ROUNDS  27  number of rounds
// PORTS
//  clk      in   1    clock, all state changes on rising edge
//  rst_n    in   1    asynchronous reset, active low
//  start    in   1    request encryption; accepted only while ready=1
//  key_in   in   M*W  key as {l[M-2],...,l[0],k0}; k0 is bits [W-1:0]
//  pt_x     in   W    plaintext high word x
//  pt_y     in   W    plaintext low word y
//  ready    out  1    1 in IDLE and DONE; start accepted this cycle
//  busy     out  1    1 while rounds are executing (RUN)
//  done     out  1    one-cycle pulse: ct_x/ct_y are valid from this cycle on
//  ct_x     out  W    ciphertext x, held until the next accepted start
//  ct_y     out  W    ciphertext y, held until the next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - state=IDLE; all regs cleared: x, y, k, l[], rnd.
//  - Outputs: ready=1, busy=0, done=0, ct_x=0, ct_y=0.
//  Round function (both instances)
//  - x' = (ROR(x,8) + y mod 2^W) ^ key;  y' = ROL(y,3) ^ x'.
//  Key-schedule step i, using the same function with x=l[0], y=k, key=i (zero-extended to W)
//  - l_new = (ROR(l[0],8) + k) ^ i;  k_next = ROL(k,3) ^ l_new.
//  - Shift l[j] <= l[j+1] for j < M-2; then l[M-2] <= l_new.
//  FSM: IDLE -> RUN -> DONE
//  - IDLE/DONE + start: load x=pt_x, y=pt_y, k=key_in[W-1:0], l[j]=key_in[(j+2)*W-1:(j+1)*W], rnd=0.
//    Next state RUN.
//  - RUN, each edge:
//    - Data round with round key k: x,y <= x',y'.
//    - Key step with i=rnd: k <= k_next, l shifts; rnd <= rnd+1.
//    - On the edge where rnd==ROUNDS-1: go to DONE; ct_x/ct_y <= final x'/y'.
//  - DONE: done=1 for exactly this cycle. Next state is IDLE, or RUN if start=1.
//  - rnd width is clog2(ROUNDS); rnd never exceeds ROUNDS-1. The final key-step result is unused.
//  Latency
//  - start sampled at edge t; done is high in cycle t+ROUNDS (27 cycles after acceptance).
//  - Throughput: one block per ROUNDS+1 cycles when start is held high.
//  Boundary conditions
//  - start while busy=1: ignored, no queueing.
//  - start in the DONE cycle: accepted. done still pulses in that cycle; ct_* change at the next done.
//  - key_in/pt_* are sampled only at acceptance; later changes have no effect on the block in flight.
//  - rst_n low during RUN: immediate abort to reset values; no done pulse; ct_* cleared.
//  - busy and ready are mutually exclusive at all times; done implies ready.
// TESTING
//  1 Reset: rst_n=0 mid-RUN -> outputs go immediately to ready=1, busy=0, done=0, ct_x=ct_y=0.
//  2 Known-answer: key=1b1a1918_13121110_0b0a0908_03020100, pt_x=3b726574, pt_y=7475432d
//    -> done exactly 27 cycles after acceptance; ct_x=8c6fa548, ct_y=454e028b.
//  3 start pulsed during RUN, and pt_*/key_in changed during RUN
//    -> no restart; ciphertext still matches the vector from scenario 2.
//  4 start held high continuously -> back-to-back blocks; done every 28 cycles; busy low only in DONE cycles.
//  5 All-zero key and plaintext -> result equals the bit-accurate software model; ct_* held until the next start.
//  6 Random key/plaintext (>=100 vectors) vs the software model; also check: done is one cycle wide,
//    busy is high for exactly 27 cycles per block, ready==!busy throughout.

Source files
------------

// File: rtl/speck_enc_ctrl.sv
// speck_enc_ctrl: iterative Speck64/128 encryption controller, one round per clock
module speck_round #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] key,
  output logic [W-1:0] x_new,
  output logic [W-1:0] y_new
);
  assign x_new = ({x[7:0], x[W-1:8]} + y) ^ key;
  assign y_new = {y[W-4:0], y[W-1:W-3]} ^ x_new;
endmodule

module speck_enc_ctrl #(
  parameter int W      = 32,
  parameter int M      = 4,
  parameter int ROUNDS = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M*W-1:0] key_in,
  input  logic [W-1:0]   pt_x,
  input  logic [W-1:0]   pt_y,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   ct_x,
  output logic [W-1:0]   ct_y
);
  localparam int RW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [W-1:0] x, y, k, x_nxt, y_nxt, l_new, k_nxt;
  logic [M-2:0][W-1:0] l;
  logic [M-1:0][W-1:0] l_sh;
  logic [RW-1:0] rnd;
  logic accept, last;
  assign ready  = state == IDLE || state == DONE;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign accept = ready && start;
  assign last   = rnd == RW'(ROUNDS - 1);
  assign l_sh   = {l_new, l};
  speck_round #(.W(W)) u_data (.x(x), .y(y), .key(k), .x_new(x_nxt), .y_new(y_nxt));
  speck_round #(.W(W)) u_key (.x(l[0]), .y(k), .key(W'(rnd)), .x_new(l_new), .y_new(k_nxt));
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // next state: an accepted start always (re)enters RUN; DONE lasts one cycle
  always_comb state_next = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  // round datapath and key schedule: load on accept, advance one round per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      k   <= '0;
      l   <= '0;
      rnd <= '0;
    end else if (accept) begin
      x   <= pt_x;
      y   <= pt_y;
      k   <= key_in[W-1:0];
      l   <= key_in[M*W-1:W];
      rnd <= '0;
    end else if (busy) begin
      x   <= x_nxt;
      y   <= y_nxt;
      k   <= k_nxt;
      l   <= l_sh[M-1:1];
      rnd <= last ? '0 : rnd + 1'b1;
    end
  end
  // ciphertext latches the final round result and holds it until the next block ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_x <= '0;
      ct_y <= '0;
    end else if (busy && last) begin
      ct_x <= x_nxt;
      ct_y <= y_nxt;
    end
  end
endmodule
